interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 101 ++++++++++
 tb/tb_interrupt_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: 8-line edge-triggered maskable interrupt controller with NMI and one level of NMI nesting
module interrupt_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic       nmi_in,
  input  logic       mask_we,
  input  logic [7:0] mask_din,
  input  logic       ina,
  input  logic       eoi,
  output logic       int_out,
  output logic       nmi_out,
  output logic [2:0] vector,
  output logic       in_svc,
  output logic [7:0] pending,
  output logic [7:0] mask
);
  typedef enum logic [2:0] {IDLE, REQ, SVC, NMI_REQ, NMI_SVC} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_irq_q, r_pending, r_mask, w_elig, w_clr;
  logic [2:0] r_vector, w_next_vec, w_pri;
  logic       r_nmi_q, r_nmi_pend, r_nested, r_int, r_nmi, r_svc;
  logic       w_clr_nmi, w_nested;
  assign w_elig = r_pending & ~r_mask;
  always_comb begin
    w_pri = 3'd0;
    for (int i = 7; i >= 0; i--) if (w_elig[i]) w_pri = 3'(i);
  end
  always_comb begin
    w_next = r_state;
    w_next_vec = r_vector;
    w_clr = 8'h00;
    w_clr_nmi = 1'b0;
    w_nested = r_nested;
    case (r_state)
      IDLE:
        if (r_nmi_pend) w_next = NMI_REQ;
        else if (|w_elig) begin
          w_next = REQ;
          w_next_vec = w_pri;
        end
      REQ:
        if (ina) begin
          w_next = SVC;
          w_clr = 8'h01 << r_vector;
        end else if (r_nmi_pend) w_next = NMI_REQ;
        else if (mask_we && mask_din[r_vector]) w_next = IDLE;
      SVC:
        if (eoi) w_next = IDLE;
        else if (r_nmi_pend) begin
          w_next = NMI_REQ;
          w_nested = 1'b1;
        end
      NMI_REQ:
        if (ina) begin
          w_next = NMI_SVC;
          w_clr_nmi = 1'b1;
        end
      NMI_SVC:
        if (eoi) begin
          w_next = r_nested ? SVC : IDLE;
          w_nested = 1'b0;
        end
      default: w_next = IDLE;
    endcase
  end
  // a new edge on the same cycle as a clear keeps the request pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_irq_q <= 8'h00;
      r_nmi_q <= 1'b0;
      r_pending <= 8'h00;
      r_nmi_pend <= 1'b0;
      r_mask <= 8'hFF;
      r_vector <= 3'd0;
      r_nested <= 1'b0;
      r_int <= 1'b0;
      r_nmi <= 1'b0;
      r_svc <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irq_q <= irq;
      r_nmi_q <= nmi_in;
      r_pending <= (r_pending & ~w_clr) | (irq & ~r_irq_q);
      r_nmi_pend <= (r_nmi_pend & ~w_clr_nmi) | (nmi_in & ~r_nmi_q);
      r_mask <= mask_we ? mask_din : r_mask;
      r_vector <= w_next_vec;
      r_nested <= w_nested;
      r_int <= w_next == REQ;
      r_nmi <= w_next == NMI_REQ;
      r_svc <= w_next == SVC || w_next == NMI_SVC;
    end
  end
  assign int_out = r_int;
  assign nmi_out = r_nmi;
  assign vector = r_vector;
  assign in_svc = r_svc;
  assign pending = r_pending;
  assign mask = r_mask;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vectors with hand-computed expectations
module tb_interrupt_controller;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] irq = 8'h00, mask_din = 8'h00;
  logic       nmi_in = 1'b0, mask_we = 1'b0, ina = 1'b0, eoi = 1'b0;
  logic       int_out, nmi_out, in_svc;
  logic [2:0] vector;
  logic [7:0] pending, mask;
  int n_vec = 0, n_err = 0;
  interrupt_controller dut (
    .clk(clk), .rst(rst), .irq(irq), .nmi_in(nmi_in), .mask_we(mask_we),
    .mask_din(mask_din), .ina(ina), .eoi(eoi), .int_out(int_out),
    .nmi_out(nmi_out), .vector(vector), .in_svc(in_svc),
    .pending(pending), .mask(mask)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic i, input logic n, input logic s, input logic [2:0] v);
    chk({tag, ".int"}, {7'd0, int_out}, {7'd0, i});
    chk({tag, ".nmi"}, {7'd0, nmi_out}, {7'd0, n});
    chk({tag, ".svc"}, {7'd0, in_svc}, {7'd0, s});
    chk({tag, ".vec"}, {5'd0, vector}, {5'd0, v});
  endtask
  initial begin
    tick(); tick();
    outs("rst", 0, 0, 0, 0);
    chk("rst.pend", pending, 8'h00);
    chk("rst.mask", mask, 8'hFF);
    rst = 0; mask_we = 1; mask_din = 8'h00; tick(); mask_we = 0;
    chk("m0", mask, 8'h00);
    // single request, full handshake
    irq = 8'h08; tick();
    chk("i3.pend", pending, 8'h08);
    outs("i3.n1", 0, 0, 0, 0);
    tick();
    outs("i3.n2", 1, 0, 0, 3);
    ina = 1; tick(); ina = 0;
    outs("i3.ina", 0, 0, 1, 3);
    chk("i3.clr", pending, 8'h00);
    eoi = 1; tick(); eoi = 0;
    outs("i3.eoi", 0, 0, 0, 3);
    irq = 8'h00; tick();
    // simultaneous edges: lowest index first
    irq = 8'h24; tick();
    chk("p.pend", pending, 8'h24);
    tick();
    outs("p.req2", 1, 0, 0, 2);
    ina = 1; tick(); ina = 0;
    chk("p.pend2", pending, 8'h20);
    eoi = 1; tick(); eoi = 0;
    outs("p.eoi", 0, 0, 0, 2);
    tick();
    outs("p.req5", 1, 0, 0, 5);
    ina = 1; tick(); ina = 0;
    eoi = 1; tick(); eoi = 0;
    chk("p.pend0", pending, 8'h00);
    irq = 8'h00; tick();
    // masked request then unmask
    mask_we = 1; mask_din = 8'hFF; tick(); mask_we = 0;
    irq = 8'h01; tick(); tick(); tick();
    chk("m.pend", pending, 8'h01);
    outs("m.held", 0, 0, 0, 5);
    mask_we = 1; mask_din = 8'hFE; tick(); mask_we = 0;
    chk("m.fe", mask, 8'hFE);
    tick();
    outs("m.req0", 1, 0, 0, 0);
    ina = 1; tick(); ina = 0;
    eoi = 1; tick(); eoi = 0;
    irq = 8'h00; mask_we = 1; mask_din = 8'h00; tick(); mask_we = 0;
    // NMI nested inside SVC of vector 4
    irq = 8'h10; tick(); tick();
    outs("n.req4", 1, 0, 0, 4);
    ina = 1; tick(); ina = 0;
    outs("n.svc4", 0, 0, 1, 4);
    nmi_in = 1; tick();
    outs("n.pend", 0, 0, 1, 4);
    tick();
    outs("n.nreq", 0, 1, 0, 4);
    eoi = 1; tick(); eoi = 0;
    outs("n.eoi_ign", 0, 1, 0, 4);
    ina = 1; tick(); ina = 0;
    outs("n.nsvc", 0, 0, 1, 4);
    eoi = 1; tick(); eoi = 0;
    outs("n.back", 0, 0, 1, 4);
    eoi = 1; tick(); eoi = 0;
    outs("n.idle", 0, 0, 0, 4);
    nmi_in = 0; irq = 8'h00; tick();
    // re-edge coinciding with clear keeps pending
    irq = 8'h08; tick(); tick();
    outs("s.req3", 1, 0, 0, 3);
    irq = 8'h00; tick();
    irq = 8'h08; ina = 1; tick(); ina = 0;
    chk("s.setwins", pending, 8'h08);
    eoi = 1; tick(); eoi = 0;
    tick();
    outs("s.again", 1, 0, 0, 3);
    ina = 1; tick(); ina = 0;
    eoi = 1; tick(); eoi = 0;
    irq = 8'h00; tick();
    // mask withdrawal in REQ
    irq = 8'h02; tick(); tick();
    outs("w.req1", 1, 0, 0, 1);
    mask_we = 1; mask_din = 8'h02; tick(); mask_we = 0;
    outs("w.wd", 0, 0, 0, 1);
    chk("w.pend", pending, 8'h02);
    chk("w.mask", mask, 8'h02);
    tick();
    chk("w.stay", {7'd0, int_out}, 8'h00);
    // reset in SVC dominates strobes
    mask_we = 1; mask_din = 8'h00; tick(); mask_we = 0;
    tick();
    outs("r.req1", 1, 0, 0, 1);
    ina = 1; irq = 8'h42; tick(); ina = 0;
    outs("r.svc", 0, 0, 1, 1);
    chk("r.pend", pending, 8'h40);
    rst = 1; eoi = 1; mask_we = 1; mask_din = 8'h00; tick();
    rst = 0; eoi = 0; mask_we = 0;
    outs("r.rst", 0, 0, 0, 0);
    chk("r.pend0", pending, 8'h00);
    chk("r.maskff", mask, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
